// File: rtl/vram_fill_pkg.sv
// Shared VRAM definitions for the fill engine and the display controller:
// fill FSM state encoding, VRAM window bounds and the {column,row} address map.
package vram_fill_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_VWAIT,
      ST_RUN,
      ST_FIN
   } fill_state_t;

   localparam logic [15:0] VRAM_BASE_ADDR = 16'h9000;
   localparam logic [15:0] VRAM_LAST_ADDR = 16'hBFFF;
   localparam int          VRAM_NCOLS     = 48;

   // Column selects the 256-byte page, row the byte within it.
   function automatic logic [15:0] vram_addr(input logic [15:0] base,
                                             input logic [5:0]  col,
                                             input logic [7:0]  row);
      return base + {2'b00, col, row};
   endfunction

endpackage

// File: rtl/rect_scan.sv
// Column-major rectangle walker: row runs y0..y1, then wraps while col advances.
module rect_scan (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       load,
   input  logic [5:0] x0,
   input  logic [5:0] x1,
   input  logic [7:0] y0,
   input  logic [7:0] y1,
   input  logic       advance,
   output logic [5:0] col,
   output logic [7:0] row,
   output logic       last
);

   logic [5:0] col_q;
   logic [5:0] x1_q;
   logic [7:0] row_q;
   logic [7:0] y0_q;
   logic [7:0] y1_q;
   logic       row_wrap;

   assign row_wrap = (row_q == y1_q);
   assign last     = row_wrap && (col_q == x1_q);
   assign col      = col_q;
   assign row      = row_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         col_q <= '0;
         row_q <= '0;
         x1_q  <= '0;
         y0_q  <= '0;
         y1_q  <= '0;
      end else if (load) begin
         col_q <= x0;
         row_q <= y0;
         x1_q  <= x1;
         y0_q  <= y0;
         y1_q  <= y1;
      end else if (advance) begin
         if (row_wrap) begin
            row_q <= y0_q;
            col_q <= col_q + 6'd1;
         end else begin
            row_q <= row_q + 8'd1;
         end
      end
   end

endmodule

// File: rtl/vram_fill.sv
// Rectangle fill engine: writes a constant bitmap/colour byte pair over a
// column/row window of video RAM, optionally synchronised to vertical blank.
module vram_fill
   import vram_fill_pkg::*;
#(
   parameter logic [15:0] VRAM_BASE = VRAM_BASE_ADDR,
   parameter int          NCOLS     = VRAM_NCOLS
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        start,
   input  logic [5:0]  x0,
   input  logic [5:0]  x1,
   input  logic [7:0]  y0,
   input  logic [7:0]  y1,
   input  logic [7:0]  fill_bmp,
   input  logic [7:0]  fill_color,
   input  logic        vsync_wait,
   input  logic        vblank,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic [15:0] addr,
   output logic [7:0]  dout,
   output logic [7:0]  color,
   output logic        we,
   output logic        busy,
   output logic        done
);

   localparam logic [6:0] NCOLS_W = 7'(NCOLS);

   fill_state_t state_q, state_d;
   logic        vblank_q;
   logic        done_q, done_d;
   logic        load;
   logic        adv;
   logic        rect_ok;
   logic [7:0]  bmp_q;
   logic [7:0]  clr_q;
   logic [5:0]  col;
   logic [7:0]  row;
   logic        last;

   logic        vld_p1;
   logic [15:0] addr_p1;
   logic [7:0]  dout_p1;
   logic [7:0]  color_p1;

   assign rect_ok = (x0 <= x1) && (y0 <= y1) && ({1'b0, x1} < NCOLS_W);
   assign adv     = (state_q == ST_RUN) && bus_gnt;

   rect_scan u_scan (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .load    (load),
      .x0      (x0),
      .x1      (x1),
      .y0      (y0),
      .y1      (y1),
      .advance (adv),
      .col     (col),
      .row     (row),
      .last    (last)
   );

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (rect_ok) begin
                  load    = 1'b1;
                  state_d = vsync_wait ? ST_VWAIT : ST_RUN;
               end else begin
                  done_d  = 1'b1;
               end
            end
         end
         ST_VWAIT: begin
            if (vblank && !vblank_q) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (adv && last) state_d = ST_FIN;
         end
         ST_FIN: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         vblank_q <= 1'b0;
         done_q   <= 1'b0;
         bmp_q    <= '0;
         clr_q    <= '0;
      end else begin
         state_q  <= state_d;
         vblank_q <= vblank;
         done_q   <= done_d;
         if (load) begin
            bmp_q <= fill_bmp;
            clr_q <= fill_color;
         end
      end
   end

   // Write stage: one registered byte per granted RUN cycle.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1   <= 1'b0;
         addr_p1  <= '0;
         dout_p1  <= '0;
         color_p1 <= '0;
      end else begin
         vld_p1 <= adv;
         if (adv) begin
            addr_p1  <= vram_addr(VRAM_BASE, col, row);
            dout_p1  <= bmp_q;
            color_p1 <= clr_q;
         end
      end
   end

   assign we      = vld_p1;
   assign addr    = addr_p1;
   assign dout    = dout_p1;
   assign color   = color_p1;
   assign done    = done_q;
   assign bus_req = (state_q == ST_RUN);
   assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vram_fill.sv
// Scoreboard bench for vram_fill: stimulus queues expected writes and done
// pulses; a negedge monitor pops and compares whatever the DUT emits.
module tb_vram_fill;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  x0 = '0, x1 = '0;
   logic [7:0]  y0 = '0, y1 = '0;
   logic [7:0]  fill_bmp = '0, fill_color = '0;
   logic        vsync_wait = 1'b0;
   logic        vblank = 1'b0;
   logic        bus_req;
   logic        bus_gnt = 1'b0;
   logic [15:0] addr;
   logic [7:0]  dout;
   logic [7:0]  color;
   logic        we;
   logic        busy;
   logic        done;

   vram_fill dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .start      (start),
      .x0         (x0),
      .x1         (x1),
      .y0         (y0),
      .y1         (y1),
      .fill_bmp   (fill_bmp),
      .fill_color (fill_color),
      .vsync_wait (vsync_wait),
      .vblank     (vblank),
      .bus_req    (bus_req),
      .bus_gnt    (bus_gnt),
      .addr       (addr),
      .dout       (dout),
      .color      (color),
      .we         (we),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk_sys = ~clk_sys;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   int          exp_done = 0;
   int          done_cnt = 0;
   int          n_we = 0;
   int          cyc = 0;
   logic        gnt_prev = 1'b0;
   logic        arm = 1'b0;
   int          first_we_cyc = -1;
   int          start_cyc = 0;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic void push(input logic [15:0] a, input logic [7:0] d, input logic [7:0] c);
      exp_q.push_back({a, d, c});
   endfunction

   // Monitor
   always @(negedge clk_sys) begin
      logic [31:0] e;
      if (we) begin
         n_we++;
         if (arm) begin
            first_we_cyc = cyc;
            arm = 1'b0;
         end
         chk("we_needs_gnt", {39'd0, gnt_prev}, 40'd1);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%h required=none", {addr, dout, color});
         end else begin
            e = exp_q.pop_front();
            chk("write", {8'd0, addr, dout, color}, {8'd0, e});
         end
      end
      if (done) begin
         done_cnt++;
         if (exp_done == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            exp_done--;
            chk("done_after_writes", 40'(exp_q.size()), 40'd0);
         end
      end
      gnt_prev = bus_gnt;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic do_start(input logic [5:0] a0, input logic [5:0] a1,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] bm, input logic [7:0] cl,
                           input logic vw);
      x0 = a0; x1 = a1; y0 = b0; y1 = b1;
      fill_bmp = bm; fill_color = cl; vsync_wait = vw;
      start_cyc = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int d0;
      int n;
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         tick();
         n++;
      end
      chk(name, {39'd0, done_cnt > d0}, 40'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n0;
      int d0;
      int n;

      // Reset state
      #1 reset_n = 1'b0;
      #1 chk("reset_outputs", {4'd0, bus_req, we, busy, done, addr, dout, color}, 40'd0);
      tick(2);
      reset_n = 1'b1;
      tick(2);

      // Small rectangle, first-write latency
      bus_gnt = 1'b1;
      push(16'h920A, 8'hA5, 8'h3C);
      push(16'h920B, 8'hA5, 8'h3C);
      push(16'h930A, 8'hA5, 8'h3C);
      push(16'h930B, 8'hA5, 8'h3C);
      exp_done++;
      arm = 1'b1;
      do_start(6'd2, 6'd3, 8'd10, 8'd11, 8'hA5, 8'h3C, 1'b0);
      chk("rect_busy_req", {38'd0, busy, bus_req}, 40'h3);
      wait_done("rect_done", 50);
      chk("first_we_latency", 40'(first_we_cyc - start_cyc), 40'd2);
      chk("rect_idle", {39'd0, busy}, 40'd0);

      // Full screen: contiguous 9000..BFFF
      for (int i = 0; i < 12288; i++) push(16'(32'h9000 + i), 8'hFF, 8'h70);
      exp_done++;
      n0 = n_we;
      do_start(6'd0, 6'd47, 8'd0, 8'd255, 8'hFF, 8'h70, 1'b0);
      wait_done("full_done", 13000);
      chk("full_count", 40'(n_we - n0), 40'd12288);
      chk("full_queue_empty", 40'(exp_q.size()), 40'd0);

      // Grant stalls at the top corner, plus a start while busy
      push(16'hBEFE, 8'h5A, 8'h0F);
      push(16'hBEFF, 8'h5A, 8'h0F);
      push(16'hBFFE, 8'h5A, 8'h0F);
      push(16'hBFFF, 8'h5A, 8'h0F);
      exp_done++;
      bus_gnt = 1'b0;
      n0 = n_we;
      do_start(6'd46, 6'd47, 8'd254, 8'd255, 8'h5A, 8'h0F, 1'b0);
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < 400) begin
         bus_gnt = 1'($urandom_range(0, 1));
         if (n == 2) begin
            x0 = 6'd0; x1 = 6'd0; y0 = 8'd0; y1 = 8'd0;
            fill_bmp = 8'h00; fill_color = 8'h00;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         n++;
      end
      start = 1'b0;
      bus_gnt = 1'b1;
      chk("stall_done", {39'd0, done_cnt > d0}, 40'd1);
      chk("stall_count", 40'(n_we - n0), 40'd4);

      // VSync wait with vblank already high
      vblank = 1'b1;
      push(16'h9100, 8'h11, 8'h22);
      push(16'h9101, 8'h11, 8'h22);
      exp_done++;
      n0 = n_we;
      do_start(6'd1, 6'd1, 8'd0, 8'd1, 8'h11, 8'h22, 1'b1);
      chk("vwait_busy_noreq", {38'd0, busy, bus_req}, 40'h2);
      tick(5);
      chk("vwait_no_we_high", 40'(n_we - n0), 40'd0);
      vblank = 1'b0;
      tick(3);
      chk("vwait_no_we_low", 40'(n_we - n0), 40'd0);
      vblank = 1'b1;
      wait_done("vsync_done", 20);
      chk("vsync_count", 40'(n_we - n0), 40'd2);
      vblank = 1'b0;
      vsync_wait = 1'b0;

      // Abort by reset after 100 writes
      for (int i = 0; i < 12288; i++) push(16'(32'h9000 + i), 8'hC3, 8'h81);
      n0 = n_we;
      do_start(6'd0, 6'd47, 8'd0, 8'd255, 8'hC3, 8'h81, 1'b0);
      n = 0;
      while ((n_we - n0) < 100 && n < 300) begin
         tick();
         n++;
      end
      chk("abort_reached_100", 40'(n_we - n0), 40'd100);
      reset_n = 1'b0;
      #1 chk("abort_outputs", {36'd0, we, busy, done, bus_req}, 40'd0);
      tick(2);
      exp_q.delete();
      d0 = done_cnt;
      reset_n = 1'b1;
      tick(5);
      chk("abort_no_done", 40'(done_cnt - d0), 40'd0);

      // Single byte at the last VRAM address after reset
      push(16'hBFFF, 8'h77, 8'h88);
      exp_done++;
      n0 = n_we;
      arm = 1'b1;
      do_start(6'd47, 6'd47, 8'd255, 8'd255, 8'h77, 8'h88, 1'b0);
      wait_done("single_done", 20);
      chk("single_latency", 40'(first_we_cyc - start_cyc), 40'd2);
      chk("single_count", 40'(n_we - n0), 40'd1);

      // Invalid rectangles: x0>x1, x1 beyond screen, y0>y1
      for (int k = 0; k < 3; k++) begin
         exp_done++;
         n0 = n_we;
         d0 = done_cnt;
         case (k)
            0:       do_start(6'd5, 6'd4, 8'd0, 8'd0, 8'h01, 8'h02, 1'b0);
            1:       do_start(6'd0, 6'd48, 8'd0, 8'd0, 8'h01, 8'h02, 1'b0);
            default: do_start(6'd0, 6'd0, 8'd9, 8'd8, 8'h01, 8'h02, 1'b0);
         endcase
         chk("invalid_not_busy", {39'd0, busy}, 40'd0);
         tick(3);
         chk("invalid_no_we", 40'(n_we - n0), 40'd0);
         chk("invalid_done_once", 40'(done_cnt - d0), 40'd1);
      end

      tick(3);
      chk("all_done_seen", 40'(exp_done), 40'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vram_fill.md
VRAM_FILL -- requirements
Module: vram_fill

Interface
REQ-001 Parameter: VRAM_BASE, 16'h9000, CPU-bus address of column 0 / row 0 of video RAM.
REQ-002 Parameter: NCOLS, 48, byte columns per screen (8 pixels each).
REQ-003 clk_sys  in  1  system clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a fill; ignored while busy.
REQ-006 x0, x1  in  6 each  first/last column, inclusive; latched on accepted start.
REQ-007 y0, y1  in  8 each  first/last row, inclusive; latched on accepted start.
REQ-008 fill_bmp  in  8  bitmap byte written; latched on start.
REQ-009 fill_color  in  8  colour byte written; latched on start.
REQ-010 vsync_wait  in  1  when latched high, writing begins only after the next vblank rising edge.
REQ-011 vblank  in  1  display vertical blank, synchronous to clk_sys.
REQ-012 bus_req  out  1  high while the engine needs the CPU bus.
REQ-013 bus_gnt  in  1  bus granted; a write is issued only in a cycle with bus_gnt high.
REQ-014 addr  out  16  write address.
REQ-015 dout  out  8  bitmap data.
REQ-016 color  out  8  colour data.
REQ-017 we  out  1  write strobe, one cycle per byte.
REQ-018 busy  out  1  high from accepted start until the last write completes.
REQ-019 done  out  1  one-cycle pulse the cycle after the last write.

Function
REQ-020 The FSM SHALL have states IDLE, VWAIT, RUN and FIN.
REQ-021 IDLE: start with x0<=x1, y0<=y1 and x1<NCOLS SHALL latch all operands and go to VWAIT if vsync_wait is high, else to RUN.
REQ-022 A start with an invalid rectangle SHALL be ignored: no busy, no writes, done pulsed for one cycle.
REQ-023 VWAIT SHALL go to RUN on the first cycle where vblank is high and was low in the previous cycle; a vblank already high on entry SHALL NOT count.
REQ-024 RUN SHALL assert bus_req; in each cycle with bus_gnt high it SHALL assert we with addr = VRAM_BASE + col*256 + row, dout = fill_bmp and color = fill_color.
REQ-025 Fill order SHALL be column-major: row increments from y0 to y1, then wraps to y0 while col increments, matching the display's {column,row} VRAM order.
REQ-026 A cycle with bus_gnt low SHALL hold col and row, keep we low, and lose no write.
REQ-027 After the write at (x1,y1), the FSM SHALL go to FIN, deassert bus_req the next cycle, pulse done for one cycle, then return to IDLE.
REQ-028 The number of writes SHALL equal exactly (x1-x0+1)*(y1-y0+1); the full screen is 12288, addresses 16'h9000..16'hBFFF.
REQ-029 Address arithmetic SHALL be 16-bit; with a valid rectangle no address exceeds VRAM_BASE+NCOLS*256-1.
REQ-030 addr, dout and color SHALL be registered; we SHALL assert in the same cycle as their values.
REQ-031 busy SHALL be high in VWAIT, RUN and FIN.
REQ-032 start while busy SHALL have no effect on latched operands.
REQ-033 Latency from an accepted start (vsync_wait low, bus_gnt held high) to the first we SHALL be 2 cycles.
REQ-034 A single-byte rectangle (x0=x1, y0=y1) SHALL produce exactly one write and then done.

Reset
REQ-035 Asserting reset_n low SHALL immediately force IDLE, with bus_req, we, busy and done at 0, and addr, dout and color at 0.
REQ-036 Reset mid-fill SHALL abort with no further writes and no done pulse.
REQ-037 After reset_n deasserts, the first accepted start SHALL behave as from power-up.

Structure
REQ-038 The FSM state enum, VRAM_BASE and the VRAM window bounds (16'h9000, 16'hBFFF) SHALL live in the shared specialist package, which the display module also uses.
REQ-039 A single sub-module, rect_scan, SHALL hold the col/row counters with advance, wrap and last outputs; the FSM stays in vram_fill.

Verification
REQ-040 Full screen: start with x 0..47, y 0..255, bmp 8'hFF, color 8'h70, bus_gnt=1 -> 12288 writes at 9000..BFFF in order, then done once.
REQ-041 Rectangle: start with x 2..3, y 10..11 -> writes in order to 920A, 920B, 930A, 930B, then done.
REQ-042 Grant stalls: bus_gnt toggling pseudo-randomly -> same address sequence, with we only in cycles where bus_gnt=1.
REQ-043 VSync wait: vsync_wait=1 and vblank already high at start -> no we until vblank falls and rises again.
REQ-044 Abort: reset_n pulsed low after 100 writes -> we=0 and busy=0 immediately, no done; a new start then works normally.
REQ-045 Invalid rectangle: x0=5, x1=4 -> no we, busy stays 0, done pulses once.
